cmd_tag_allocator: RTL and testbench
====================================

// Module: cmd_tag_allocator
// PURPOSE
//  Parametrised command-tag pool for the AFU command path. Issues unique tags to command
//  generators, records the requesting cu_id per tag, returns the owner on response lookup,
//  and frees the tag on release. Sits between the command arbiter and the PSL command/response
//  interfaces; tag 0 (INVALID_TAG) is never issued.
// PARAMETERS
//  TAG_COUNT    32  total tag slots incl. reserved tag 0; usable tags 1..TAG_COUNT-1 (>=4, pow2)
//  CU_ID_RANGE  8   width of cu_id_t stored per tag
//  TAG_W        $clog2(TAG_COUNT)  tag width (derived, not overridden)
// PORTS
//  clock            in   1            single clock
//  reset            in   1            asynchronous, active-high
//  enabled          in   1            0: no grants issued; releases/lookups still served
//  flush            in   1            1-cycle pulse: free all tags, clear table
//  alloc_req        in   1            request one tag this cycle
//  alloc_cu_id      in   CU_ID_RANGE  owner recorded with granted tag
//  alloc_gnt        out  1            1-cycle pulse: alloc_tag valid
//  alloc_tag        out  TAG_W        granted tag
//  release_valid    in   1            return a tag (response received)
//  release_tag      in   TAG_W        tag being returned
//  lookup_valid     in   1            owner query for response routing
//  lookup_tag       in   TAG_W        tag queried
//  lookup_rsp_valid out  1            lookup result valid (1 cycle after lookup_valid)
//  lookup_cu_id     out  CU_ID_RANGE  owner of lookup_tag; INVALID_ID if tag not in use
//  lookup_hit       out  1            1 if lookup_tag was in use
//  free_count       out  TAG_W+1      number of free usable tags
//  tags_empty       out  1            free_count==0 (registered)
//  error_release    out  1            sticky: release of free tag or tag 0; cleared by reset/flush
// BEHAVIOUR
//  - Reset: free vector = all usable tags free, table = INVALID_ID, alloc_gnt=0, alloc_tag=0,
//    lookup_rsp_valid=0, lookup_cu_id=INVALID_ID, lookup_hit=0, free_count=TAG_COUNT-1,
//    tags_empty=0, error_release=0. Reset mid-operation discards all outstanding tags.
//  - Allocation: alloc_req & enabled & free tag exists in cycle N -> alloc_gnt=1 in N+1 with
//    lowest-index free tag; tag marked busy and cu_id written at the same edge. One grant/cycle;
//    back-to-back requests each cycle get distinct tags. No free tag or enabled=0: request
//    dropped, alloc_gnt=0 (requester holds alloc_req and retries; no queuing inside).
//  - Release: release_valid with busy tag in cycle N -> tag free from N+1; table entry set
//    INVALID_ID. A tag released in cycle N is NOT grantable by a request in cycle N (grant
//    uses pre-release free vector); grantable from N+1.
//  - Release of already-free tag or tag 0: ignored, error_release set (sticky).
//  - Simultaneous alloc and release: both take effect; free_count = old - 1 + 1.
//  - Lookup: registered, 1-cycle latency; reads table state before same-cycle release/alloc
//    (lookup and release of same tag same cycle returns owner, hit=1).
//  - Flush: highest priority; in the flush cycle alloc/release ignored, alloc_gnt next cycle=0;
//    all tags free, free_count=TAG_COUNT-1, error_release cleared, from N+1.
//  - free_count/tags_empty updated registered, consistent with free vector each cycle;
//    free_count never exceeds TAG_COUNT-1 nor underflows.
// STRUCTURE
//  - GLOBALS_PKG: TAG_COUNT, INVALID_TAG, CU_ID_RANGE, INVALID_ID, cu_id_t; add
//    typedef tag_t (logic [0:TAG_W-1]) and struct tag_alloc_t {valid, tag, cu_id}.
//  - Sub-module tag_priority_encoder (param WIDTH): lowest set bit index + found flag,
//    bit 0 masked off by caller. Free vector + cu_id table as flops in this module.
// TESTING
//  - Reset then alloc_req x31 back-to-back, cu_id=i -> tags 1..31 in order, free_count 31->0,
//    tags_empty=1 after last; 32nd request -> no grant.
//  - Pool full, release tag 7 and alloc_req same cycle -> no grant that cycle; next-cycle
//    request -> grant tag 7, free_count stays 0 after.
//  - Alloc tag 3 with cu_id=8'hFE, lookup 3 -> next cycle lookup_cu_id=8'hFE, hit=1; release 3
//    then lookup 3 -> lookup_cu_id=8'h00, hit=0.
//  - Release tag 5 while free, then release tag 0 -> error_release=1 sticky, free_count
//    unchanged; flush -> error_release=0, free_count=31.
//  - enabled=0 with alloc_req held 10 cycles -> no grants; enabled=1 -> grant tag 1 next cycle.
//  - Assert reset asynchronously with 12 tags outstanding -> outputs at reset values without
//    clock edge; after release, first grant is tag 1.

Source files
------------

// File: rtl/cmd_tag_allocator_pkg.sv
// Shared constants and types for the command-tag pool: tag/owner widths,
// reserved values and the grant record.
package cmd_tag_allocator_pkg;

  localparam int TAG_COUNT   = 32;
  localparam int TAG_W       = $clog2(TAG_COUNT);
  localparam int CU_ID_RANGE = 8;

  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [CU_ID_RANGE-1:0] cu_id_t;
  typedef logic [TAG_W:0]         count_t;

  localparam tag_t   INVALID_TAG = '0;
  localparam cu_id_t INVALID_ID  = '0;
  localparam count_t USABLE_TAGS = count_t'(TAG_COUNT - 1);

  typedef struct packed {
    logic   valid;
    tag_t   tag;
    cu_id_t cu_id;
  } tag_alloc_t;

  // Free vector with every usable tag free; tag 0 is never free.
  function automatic logic [TAG_COUNT-1:0] all_usable_free();
    return {{(TAG_COUNT-1){1'b1}}, 1'b0};
  endfunction

endpackage

// File: rtl/cmd_tag_allocator_tag_priority_encoder.sv
// Lowest-set-bit priority encoder; reports the index and whether any bit
// was set.
module tag_priority_encoder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         req_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     found_o
);

  localparam int IDX_W = $clog2(WIDTH);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_tag_allocator.sv
// Command-tag pool: grants the lowest free tag, records the owner cu_id,
// serves registered owner lookups and frees tags on release.
module cmd_tag_allocator
  import cmd_tag_allocator_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enabled,
  input  logic                   flush,
  input  logic                   alloc_req,
  input  logic [CU_ID_RANGE-1:0] alloc_cu_id,
  output logic                   alloc_gnt,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic                   release_valid,
  input  logic [TAG_W-1:0]       release_tag,
  input  logic                   lookup_valid,
  input  logic [TAG_W-1:0]       lookup_tag,
  output logic                   lookup_rsp_valid,
  output logic [CU_ID_RANGE-1:0] lookup_cu_id,
  output logic                   lookup_hit,
  output logic [TAG_W:0]         free_count,
  output logic                   tags_empty,
  output logic                   error_release
);

  logic [TAG_COUNT-1:0] free_q, free_d;
  cu_id_t               owner_q [TAG_COUNT];
  cu_id_t               owner_d [TAG_COUNT];
  count_t               count_q, count_d;
  logic                 empty_q;
  logic                 err_q, err_d;
  logic                 gnt_q;
  tag_t                 gnt_tag_q;
  logic                 lk_valid_q, lk_hit_q, lk_hit_d;
  cu_id_t               lk_cu_q, lk_cu_d;

  tag_alloc_t           grant_d;
  logic [TAG_COUNT-1:0] cand;
  tag_t                 enc_idx;
  logic                 enc_found;
  logic                 rel_hit;

  // Tag 0 is reserved, so it is masked out of the grant candidates.
  assign cand = {free_q[TAG_COUNT-1:1], 1'b0};

  tag_priority_encoder #(.WIDTH(TAG_COUNT)) u_enc (
    .req_i   (cand),
    .idx_o   (enc_idx),
    .found_o (enc_found)
  );

  always_comb begin
    rel_hit = release_valid && (release_tag != INVALID_TAG) && !free_q[release_tag];
    grant_d = '{valid: 1'b0, tag: INVALID_TAG, cu_id: INVALID_ID};
    free_d  = free_q;
    owner_d = owner_q;
    count_d = count_q;
    err_d   = err_q | (release_valid && !rel_hit);

    if (flush) begin
      free_d = all_usable_free();
      for (int i = 0; i < TAG_COUNT; i++) owner_d[i] = INVALID_ID;
      count_d = USABLE_TAGS;
      err_d   = 1'b0;
    end else begin
      // Grant works on the pre-release vector: a tag freed now is grantable next cycle.
      if (alloc_req && enabled && enc_found) begin
        grant_d = '{valid: 1'b1, tag: enc_idx, cu_id: alloc_cu_id};
        free_d[grant_d.tag]  = 1'b0;
        owner_d[grant_d.tag] = grant_d.cu_id;
      end
      if (rel_hit) begin
        free_d[release_tag]  = 1'b1;
        owner_d[release_tag] = INVALID_ID;
      end
      count_d = count_q - count_t'(grant_d.valid) + count_t'(rel_hit);
    end

    // Lookup sees the table as it stands before this cycle's alloc/release.
    lk_hit_d = lookup_valid && (lookup_tag != INVALID_TAG) && !free_q[lookup_tag];
    lk_cu_d  = lk_hit_d ? owner_q[lookup_tag] : INVALID_ID;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_q     <= all_usable_free();
      count_q    <= USABLE_TAGS;
      empty_q    <= 1'b0;
      err_q      <= 1'b0;
      gnt_q      <= 1'b0;
      gnt_tag_q  <= INVALID_TAG;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_cu_q    <= INVALID_ID;
    end else begin
      free_q     <= free_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      err_q      <= err_d;
      gnt_q      <= grant_d.valid;
      gnt_tag_q  <= grant_d.tag;
      lk_valid_q <= lookup_valid;
      lk_hit_q   <= lk_hit_d;
      lk_cu_q    <= lk_cu_d;
    end
  end

  // NOTE: the owner table is reset because lookups of freed tags must read INVALID_ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAG_COUNT; i++) owner_q[i] <= INVALID_ID;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign alloc_gnt        = gnt_q;
  assign alloc_tag        = gnt_tag_q;
  assign lookup_rsp_valid = lk_valid_q;
  assign lookup_hit       = lk_hit_q;
  assign lookup_cu_id     = lk_cu_q;
  assign free_count       = count_q;
  assign tags_empty       = empty_q;
  assign error_release    = err_q;

endmodule

// File: tb/tb_cmd_tag_allocator.sv
// Directed, table-driven bench for cmd_tag_allocator with hand-written
// sequences for asynchronous reset.
module tb_cmd_tag_allocator;
  import cmd_tag_allocator_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         enabled, flush, alloc_req, release_valid, lookup_valid;
  logic [7:0]   alloc_cu_id;
  logic [4:0]   release_tag, lookup_tag;
  logic         alloc_gnt, lookup_rsp_valid, lookup_hit, tags_empty, error_release;
  logic [4:0]   alloc_tag;
  logic [7:0]   lookup_cu_id;
  logic [5:0]   free_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en, req;
    logic [7:0] cu;
    logic       rel;
    logic [4:0] rtag;
    logic       lk;
    logic [4:0] ltag;
    logic       fl;
    logic       gnt;
    logic [4:0] tag;
    logic [5:0] fc;
    logic       empty, err, lrv, hit;
    logic [7:0] lcu;
  } vec_t;

  vec_t vecs[$];

  cmd_tag_allocator dut (
    .clock            (clock),
    .reset            (reset),
    .enabled          (enabled),
    .flush            (flush),
    .alloc_req        (alloc_req),
    .alloc_cu_id      (alloc_cu_id),
    .alloc_gnt        (alloc_gnt),
    .alloc_tag        (alloc_tag),
    .release_valid    (release_valid),
    .release_tag      (release_tag),
    .lookup_valid     (lookup_valid),
    .lookup_tag       (lookup_tag),
    .lookup_rsp_valid (lookup_rsp_valid),
    .lookup_cu_id     (lookup_cu_id),
    .lookup_hit       (lookup_hit),
    .free_count       (free_count),
    .tags_empty       (tags_empty),
    .error_release    (error_release)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic req, input logic [7:0] cu,
                              input logic rel, input logic [4:0] rtag,
                              input logic lk, input logic [4:0] ltag, input logic fl,
                              input logic gnt, input logic [4:0] tag, input logic [5:0] fc,
                              input logic empty, input logic err, input logic lrv,
                              input logic hit, input logic [7:0] lcu);
    vec_t v;
    v.en = en; v.req = req; v.cu = cu; v.rel = rel; v.rtag = rtag;
    v.lk = lk; v.ltag = ltag; v.fl = fl;
    v.gnt = gnt; v.tag = tag; v.fc = fc; v.empty = empty; v.err = err;
    v.lrv = lrv; v.hit = hit; v.lcu = lcu;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    enabled = 1'b1; flush = 1'b0; alloc_req = 1'b0; alloc_cu_id = '0;
    release_valid = 1'b0; release_tag = '0; lookup_valid = 1'b0; lookup_tag = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " gnt"},   32'(alloc_gnt), 0);
    check({tag, " tag"},   32'(alloc_tag), 0);
    check({tag, " lrv"},   32'(lookup_rsp_valid), 0);
    check({tag, " lcu"},   32'(lookup_cu_id), 0);
    check({tag, " hit"},   32'(lookup_hit), 0);
    check({tag, " fc"},    32'(free_count), 31);
    check({tag, " empty"}, 32'(tags_empty), 0);
    check({tag, " err"},   32'(error_release), 0);
  endtask

  initial begin
    // Fill 31 tags in order, then exercise full pool, lookup, release, flush.
    for (int i = 1; i <= 31; i++)
      add(1, 1, 8'(i), 0, 0, 0, 0, 0,  1, 5'(i), 6'(31 - i), (i == 31), 0, 0, 0, 0);
    add(1, 1, 8'h20, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 8'h21, 1, 7, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 8'h77, 0, 0, 0, 0, 0,  1, 7, 0, 1, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 7, 0,  0, 0, 0, 1, 0, 1, 1, 8'h77);
    add(1, 0, 8'h00, 1, 7, 1, 7, 0,  0, 0, 1, 0, 0, 1, 1, 8'h77);
    add(1, 0, 8'h00, 0, 0, 1, 7, 0,  0, 0, 1, 0, 0, 1, 0, 8'h00);
    add(1, 0, 8'h00, 1, 3, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0);
    add(1, 1, 8'hFE, 0, 0, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 3, 0,  0, 0, 1, 0, 0, 1, 1, 8'hFE);
    add(1, 0, 8'h00, 1, 3, 0, 0, 0,  0, 0, 2, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 3, 0,  0, 0, 2, 0, 0, 1, 0, 8'h00);
    add(1, 0, 8'h00, 0, 0, 1, 10, 0, 0, 0, 2, 0, 0, 1, 1, 8'h0A);
    add(1, 1, 8'h55, 1, 1, 0, 0, 1,  0, 0, 31, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1, 5, 0, 0, 0,  0, 0, 31, 0, 1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0, 0,  0, 0, 31, 0, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0,  0, 0, 31, 0, 1, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 1,  0, 0, 31, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 1, 8'h11, 0, 0, 0, 0, 0,  0, 0, 31, 0, 0, 0, 0, 0);
    add(1, 1, 8'h11, 0, 0, 0, 0, 0,  1, 1, 30, 0, 0, 0, 0, 0);
    add(1, 1, 8'h22, 1, 1, 0, 0, 0,  1, 2, 30, 0, 0, 0, 0, 0);
    add(1, 1, 8'h33, 0, 0, 0, 0, 0,  1, 1, 29, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0,  0, 0, 29, 0, 0, 1, 1, 8'h33);
    add(1, 0, 8'h00, 0, 0, 0, 0, 1,  0, 0, 31, 0, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 2, 0,  0, 0, 31, 0, 0, 1, 0, 8'h00);

    idle_inputs();
    reset = 1'b1;
    #2;
    check_reset_values("reset");
    tick();
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t v;
      string nm;
      v = vecs[k];
      enabled = v.en; alloc_req = v.req; alloc_cu_id = v.cu;
      release_valid = v.rel; release_tag = v.rtag;
      lookup_valid = v.lk; lookup_tag = v.ltag; flush = v.fl;
      tick();
      nm = $sformatf("v%0d", k);
      check({nm, " gnt"},   32'(alloc_gnt), 32'(v.gnt));
      if (v.gnt) check({nm, " tag"}, 32'(alloc_tag), 32'(v.tag));
      check({nm, " fc"},    32'(free_count), 32'(v.fc));
      check({nm, " empty"}, 32'(tags_empty), 32'(v.empty));
      check({nm, " err"},   32'(error_release), 32'(v.err));
      check({nm, " lrv"},   32'(lookup_rsp_valid), 32'(v.lrv));
      if (v.lrv) begin
        check({nm, " hit"}, 32'(lookup_hit), 32'(v.hit));
        check({nm, " lcu"}, 32'(lookup_cu_id), 32'(v.lcu));
      end
    end
    idle_inputs();

    // Twelve outstanding tags, plus a bad release and a lookup, then async reset.
    for (int i = 1; i <= 12; i++) begin
      alloc_req = 1'b1;
      alloc_cu_id = 8'(8'h40 + i);
      if (i == 12) begin
        release_valid = 1'b1; release_tag = '0;
        lookup_valid  = 1'b1; lookup_tag  = 5'd4;
      end
      tick();
      check($sformatf("out%0d gnt", i), 32'(alloc_gnt), 1);
      check($sformatf("out%0d tag", i), 32'(alloc_tag), 32'(i));
    end
    check("pre_rst fc",  32'(free_count), 19);
    check("pre_rst err", 32'(error_release), 1);
    check("pre_rst lrv", 32'(lookup_rsp_valid), 1);
    check("pre_rst lcu", 32'(lookup_cu_id), 32'h44);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    #2;
    reset = 1'b0;
    alloc_req = 1'b1;
    alloc_cu_id = 8'h99;
    tick();
    check("post_rst gnt", 32'(alloc_gnt), 1);
    check("post_rst tag", 32'(alloc_tag), 1);
    check("post_rst fc",  32'(free_count), 30);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
